// File: rtl/result_requant_streamer.sv
// Captures the systolic-array result matrix on its valid pulse, requantizes it to int8
// and streams it out one row per valid/ready transfer.
module result_requant_streamer #(
  parameter int N       = 16,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic                                       i_clk,
  input  logic                                       i_arst,
  input  logic signed [N-1:0][N-1:0][ACC_W-1:0]      i_c,
  input  logic                                       i_validResult,
  input  logic        [SHIFT_W-1:0]                  i_shift,
  input  logic                                       i_relu,
  output logic signed [N-1:0][OUT_W-1:0]             o_row_data,
  output logic        [$clog2(N)-1:0]                o_row_idx,
  output logic                                       o_row_valid,
  input  logic                                       i_row_ready,
  output logic                                       o_last,
  output logic                                       o_done,
  output logic                                       o_busy,
  output logic                                       o_overrun
);

  localparam int IDX_W = $clog2(N);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -(ACC_W+1)'(2**(OUT_W-1));

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t                          state;
  logic [N-1:0][N-1:0][ACC_W-1:0]  cap;
  logic [SHIFT_W-1:0]              shift_q;
  logic                            relu_q;
  logic [IDX_W-1:0]                row_sel;
  logic [N-1:0][OUT_W-1:0]         next_row;

  // Rounding term is 2^(s-1) for s>0 and 0 for s==0, so one path covers both cases.
  // The 33-bit sum cannot overflow even for the largest positive input.
  function automatic logic [N-1:0][OUT_W-1:0] requant_row(
    input logic [N-1:0][ACC_W-1:0] row,
    input logic [SHIFT_W-1:0]      shift,
    input logic                    relu
  );
    logic signed [ACC_W:0]   ext;
    logic signed [ACC_W:0]   rnd;
    logic signed [ACC_W:0]   y;
    logic [N-1:0][OUT_W-1:0] res;
    res = '0;
    for (int i = 0; i < N; i++) begin
      ext = $signed({row[i][ACC_W-1], row[i]});
      rnd = $signed(({{ACC_W{1'b0}}, 1'b1} << shift) >> 1);
      y   = (ext + rnd) >>> shift;
      if (relu && y < 0) y = '0;
      if (y > SAT_MAX) y = SAT_MAX;
      else if (y < SAT_MIN) y = SAT_MIN;
      res[i] = y[OUT_W-1:0];
    end
    return res;
  endfunction

  // Row 0 is loaded from LOAD; in STREAM the successor row is prepared ahead of the transfer.
  always_comb begin
    row_sel  = (state == STREAM) ? o_row_idx + 1'b1 : '0;
    next_row = requant_row(cap[row_sel], shift_q, relu_q);
  end

  always_ff @(posedge i_clk) begin
    if (state == IDLE && i_validResult) begin
      cap     <= i_c;
      shift_q <= i_shift;
      relu_q  <= i_relu;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state       <= IDLE;
      o_row_data  <= '0;
      o_row_idx   <= '0;
      o_row_valid <= 1'b0;
      o_last      <= 1'b0;
      o_done      <= 1'b0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      o_overrun <= i_validResult && (state != IDLE);
      case (state)
        IDLE: begin
          if (i_validResult) begin
            o_row_idx <= '0;
            o_busy    <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          o_row_data  <= next_row;
          o_row_idx   <= '0;
          o_row_valid <= 1'b1;
          o_last      <= (N == 1);
          state       <= STREAM;
        end
        STREAM: begin
          if (o_row_valid && i_row_ready) begin
            if (o_row_idx == IDX_W'(N-1)) begin
              o_row_valid <= 1'b0;
              o_last      <= 1'b0;
              o_done      <= 1'b1;
              o_busy      <= 1'b0;
              state       <= IDLE;
            end else begin
              o_row_data <= next_row;
              o_row_idx  <= row_sel;
              o_last     <= (row_sel == IDX_W'(N-1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_requant_streamer.sv
// Directed bench for result_requant_streamer: per-element arithmetic vectors from a table,
// plus hand-written sequences for latency, backpressure, overrun and mid-stream reset.
module tb_result_requant_streamer;

  localparam int N       = 16;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;
  localparam int NVEC    = 17;

  typedef struct {
    int x;
    int shift;
    bit relu;
    int expected;
  } vec_t;

  logic                           clk = 1'b0;
  logic                           arst;
  logic [N-1:0][N-1:0][ACC_W-1:0] c;
  logic                           validResult;
  logic [SHIFT_W-1:0]             shiftAmt;
  logic                           relu;
  logic [N-1:0][OUT_W-1:0]        rowData;
  logic [3:0]                     rowIdx;
  logic                           rowValid;
  logic                           rowReady;
  logic                           last;
  logic                           done;
  logic                           busy;
  logic                           overrun;

  int   applied = 0;
  int   miscompares = 0;
  int   constVal = 0;
  vec_t vecs[NVEC];

  result_requant_streamer #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) dut (
    .i_clk(clk), .i_arst(arst), .i_c(c), .i_validResult(validResult),
    .i_shift(shiftAmt), .i_relu(relu), .o_row_data(rowData), .o_row_idx(rowIdx),
    .o_row_valid(rowValid), .i_row_ready(rowReady), .o_last(last), .o_done(done),
    .o_busy(busy), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Pattern 0 and 1 stay inside int8 so with shift 0 the output equals the input.
  function automatic int expElem(input int pattern, input int r, input int col);
    case (pattern)
      0:       return r * N + col - 128;
      1:       return 127 - (r * N + col);
      default: return constVal;
    endcase
  endfunction

  task automatic fillMatrix(input int pattern, input int fillVal);
    for (int r = 0; r < N; r++)
      for (int col = 0; col < N; col++)
        c[r][col] = (pattern == 2) ? ACC_W'(fillVal) : ACC_W'(expElem(pattern, r, col));
  endtask

  // Called at a negedge; the result pulse spans one posedge, then inputs are scrambled.
  task automatic applyStimulus(input int pattern, input int fillVal, input int shiftIn, input bit reluIn);
    fillMatrix(pattern, fillVal);
    shiftAmt    = SHIFT_W'(shiftIn);
    relu        = reluIn;
    validResult = 1'b1;
    @(negedge clk);
    validResult = 1'b0;
    c           = {N*N{32'hA5A55A5A}};
    shiftAmt    = 5'd3;
    relu        = ~reluIn;
    checkOutput("load_busy", busy, 1'b1);
    checkOutput("load_valid", rowValid, 1'b0);
  endtask

  task automatic streamRows(input int pattern, input bit randomReady, input int injectRow,
                            input bit pulseAtLast, output int cycles);
    int transfers = 0;
    bit stalled = 0;
    bit injected = 0;
    int injectAge = 0;
    logic [N-1:0][OUT_W-1:0] held;
    logic [N-1:0][OUT_W-1:0] expRow;
    logic [3:0] heldIdx;
    cycles = 0;
    while (transfers < N && cycles < 1000) begin
      @(negedge clk);
      cycles++;
      if (injectAge == 1) begin
        validResult = 1'b0;
        checkOutput("overrun_pulse", overrun, 1'b1);
        injectAge = 2;
      end else if (injectAge == 2) begin
        checkOutput("overrun_clear", overrun, 1'b0);
        injectAge = 3;
      end
      if (stalled) begin
        checkOutput("stall_valid", rowValid, 1'b1);
        checkOutput("stall_data", rowData, held);
        checkOutput("stall_idx", rowIdx, heldIdx);
      end
      if (rowValid) begin
        for (int col = 0; col < N; col++) expRow[col] = OUT_W'(expElem(pattern, transfers, col));
        checkOutput("row_idx", rowIdx, transfers[3:0]);
        checkOutput("row_data", rowData, expRow);
        checkOutput("row_last", last, transfers == N-1);
        rowReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
        if (injectRow >= 0 && !injected && transfers == injectRow) begin
          rowReady    = 1'b0;
          validResult = 1'b1;
          fillMatrix(1, 0);
          injected  = 1;
          injectAge = 1;
        end
        if (pulseAtLast && transfers == N-1 && rowReady) begin
          validResult = 1'b1;
          fillMatrix(1, 0);
        end
        if (rowReady) begin
          transfers++;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = rowData;
          heldIdx = rowIdx;
        end
      end else begin
        stalled = 0;
      end
    end
    checkOutput("transfer_count", transfers, N);
  endtask

  task automatic finishMatrix();
    @(negedge clk);
    checkOutput("done_pulse", done, 1'b1);
    checkOutput("valid_after_last", rowValid, 1'b0);
    checkOutput("busy_after_last", busy, 1'b0);
    @(negedge clk);
    checkOutput("done_clear", done, 1'b0);
  endtask

  initial begin
    int  cyc;
    bit  found;
    vecs[0]  = '{8,            4,  1'b0, 1};
    vecs[1]  = '{7,            4,  1'b0, 0};
    vecs[2]  = '{-8,           4,  1'b0, 0};
    vecs[3]  = '{-9,           4,  1'b0, -1};
    vecs[4]  = '{5000,         4,  1'b0, 127};
    vecs[5]  = '{-5000,        4,  1'b0, -128};
    vecs[6]  = '{32'h7FFFFFFF, 31, 1'b0, 1};
    vecs[7]  = '{-5,           0,  1'b1, 0};
    vecs[8]  = '{0,            0,  1'b1, 0};
    vecs[9]  = '{42,           0,  1'b1, 42};
    vecs[10] = '{300,          0,  1'b1, 127};
    vecs[11] = '{-3,           1,  1'b0, -1};
    vecs[12] = '{3,            1,  1'b0, 2};
    vecs[13] = '{32'sh80000000, 31, 1'b0, -1};
    vecs[14] = '{-200,         2,  1'b1, 0};
    vecs[15] = '{-129,         0,  1'b0, -128};
    vecs[16] = '{128,          0,  1'b0, 127};

    arst        = 1'b1;
    validResult = 1'b0;
    rowReady    = 1'b0;
    shiftAmt    = '0;
    relu        = 1'b0;
    c           = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_valid", rowValid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_last", last, 1'b0);
    checkOutput("reset_overrun", overrun, 1'b0);
    checkOutput("reset_idx", rowIdx, 4'd0);
    checkOutput("reset_data", rowData, 128'd0);
    arst = 1'b0;
    @(negedge clk);

    $display("[TB] identity pass");
    applyStimulus(0, 0, 0, 1'b0);
    streamRows(0, 1'b0, -1, 1'b0, cyc);
    checkOutput("identity_row_cycles", cyc, N);
    finishMatrix();

    $display("[TB] arithmetic vectors");
    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(2, vecs[v].x, vecs[v].shift, vecs[v].relu);
      constVal = vecs[v].expected;
      streamRows(2, 1'b0, -1, 1'b0, cyc);
      finishMatrix();
    end

    $display("[TB] random backpressure");
    applyStimulus(1, 0, 0, 1'b0);
    streamRows(1, 1'b1, -1, 1'b0, cyc);
    finishMatrix();

    $display("[TB] overrun during row 5 stall");
    applyStimulus(0, 0, 0, 1'b0);
    streamRows(0, 1'b1, 5, 1'b0, cyc);
    finishMatrix();

    $display("[TB] pulse on final transfer dropped, pulse in done cycle accepted");
    applyStimulus(1, 0, 0, 1'b0);
    streamRows(1, 1'b0, -1, 1'b1, cyc);
    @(negedge clk);
    checkOutput("done_with_overrun", done, 1'b1);
    checkOutput("overrun_on_last", overrun, 1'b1);
    applyStimulus(0, 0, 0, 1'b0);
    streamRows(0, 1'b0, -1, 1'b0, cyc);
    checkOutput("restart_row_cycles", cyc, N);
    finishMatrix();

    $display("[TB] reset mid-stream");
    applyStimulus(1, 0, 0, 1'b0);
    rowReady = 1'b1;
    found    = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (rowValid && rowIdx == 4'd7) begin
        rowReady = 1'b0;
        found    = 1;
      end
    end
    checkOutput("reached_row7", found, 1'b1);
    #2;
    arst = 1'b1;
    #1;
    checkOutput("arst_valid", rowValid, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_done", done, 1'b0);
    checkOutput("arst_last", last, 1'b0);
    checkOutput("arst_data", rowData, 128'd0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_done", done, 1'b0);
    applyStimulus(0, 0, 0, 1'b0);
    streamRows(0, 1'b1, -1, 1'b0, cyc);
    finishMatrix();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
